// File: rtl/key_serial_loader.sv
// key_serial_loader: receives a serial key and its checksum, then presents the key only after the checksum matches.
// Repeated checksum failures latch a lockout that only reset clears.
module key_serial_loader #(
  parameter int KEY_WIDTH  = 32,
  parameter int CHK_WIDTH  = 8,
  parameter int FAIL_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_bit,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 key_error,
  output logic                 busy,
  output logic                 locked,
  output logic [2:0]           fail_count
);
  localparam int CW = $clog2(KEY_WIDTH);
  typedef enum logic [2:0] {IDLE, SHIFT_KEY, SHIFT_CHK, CHECK, DONE, LOCKED} state_t;
  state_t state_q, state_d;
  logic [KEY_WIDTH-1:0] sr_q, sr_d, key_out_q, key_out_d;
  logic [CHK_WIDTH-1:0] chk_q, chk_d, exp_chk;
  logic [CW-1:0] cnt_q, cnt_d;
  logic key_valid_q, key_valid_d, key_error_q, key_error_d;
  logic busy_q, busy_d, locked_q, locked_d, in_ready_q, in_ready_d;
  logic [2:0] fail_count_q, fail_count_d;
  logic acc;
  assign acc = in_valid && in_ready_q;
  always_comb begin
    exp_chk = '0;
    for (int i = 0; i < KEY_WIDTH / 8; i++) exp_chk ^= sr_q[i*8 +: 8];
  end
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    chk_d        = chk_q;
    cnt_d        = cnt_q;
    key_out_d    = key_out_q;
    key_valid_d  = key_valid_q;
    key_error_d  = key_error_q;
    fail_count_d = fail_count_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d     = SHIFT_KEY;
        key_out_d   = '0;
        key_valid_d = 1'b0;
        key_error_d = 1'b0;
        sr_d        = '0;
        chk_d       = '0;
        cnt_d       = '0;
      end
      SHIFT_KEY, SHIFT_CHK: begin
        if (start) begin
          state_d = SHIFT_KEY;
          sr_d    = '0;
          chk_d   = '0;
          cnt_d   = '0;
        end else if (acc && state_q == SHIFT_KEY) begin
          sr_d    = {sr_q[KEY_WIDTH-2:0], in_bit};
          cnt_d   = (cnt_q == CW'(KEY_WIDTH - 1)) ? '0 : cnt_q + 1'b1;
          state_d = (cnt_q == CW'(KEY_WIDTH - 1)) ? SHIFT_CHK : SHIFT_KEY;
        end else if (acc) begin
          chk_d   = {chk_q[CHK_WIDTH-2:0], in_bit};
          cnt_d   = (cnt_q == CW'(CHK_WIDTH - 1)) ? '0 : cnt_q + 1'b1;
          state_d = (cnt_q == CW'(CHK_WIDTH - 1)) ? CHECK : SHIFT_CHK;
        end
      end
      CHECK: if (chk_q == exp_chk) begin
        key_out_d   = sr_q;
        key_valid_d = 1'b1;
        state_d     = DONE;
      end else begin
        key_error_d  = 1'b1;
        fail_count_d = (fail_count_q < 3'(FAIL_LIMIT)) ? fail_count_q + 3'd1 : fail_count_q;
        state_d      = (fail_count_d == 3'(FAIL_LIMIT)) ? LOCKED : DONE;
      end
      LOCKED: begin
        key_out_d   = '0;
        key_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // Status flags are registered from the next state so they never depend on in_valid.
    in_ready_d = (state_d == SHIFT_KEY) || (state_d == SHIFT_CHK);
    busy_d     = in_ready_d || (state_d == CHECK);
    locked_d   = state_d == LOCKED;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      chk_q        <= '0;
      cnt_q        <= '0;
      key_out_q    <= '0;
      key_valid_q  <= 1'b0;
      key_error_q  <= 1'b0;
      fail_count_q <= 3'd0;
      busy_q       <= 1'b0;
      locked_q     <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      chk_q        <= chk_d;
      cnt_q        <= cnt_d;
      key_out_q    <= key_out_d;
      key_valid_q  <= key_valid_d;
      key_error_q  <= key_error_d;
      fail_count_q <= fail_count_d;
      busy_q       <= busy_d;
      locked_q     <= locked_d;
      in_ready_q   <= in_ready_d;
    end
  end
  assign in_ready   = in_ready_q;
  assign key_out    = key_out_q;
  assign key_valid  = key_valid_q;
  assign key_error  = key_error_q;
  assign busy       = busy_q;
  assign locked     = locked_q;
  assign fail_count = fail_count_q;
endmodule

// File: tb/tb_key_serial_loader.sv
// tb_key_serial_loader: randomized loads checked by a scoreboard against a byte-XOR checksum model.
// Expected load results are queued at stimulus time and popped whenever busy falls.
module tb_key_serial_loader;
  localparam int KW = 32;
  localparam int LIMIT = 3;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_bit = 1'b0, in_valid = 1'b0;
  logic in_ready, key_valid, key_error, busy, locked;
  logic [KW-1:0] key_out;
  logic [2:0] fail_count;
  logic [KW+5:0] exp_q[$];
  int checks = 0, errors = 0, mfc = 0;
  bit mlock = 0, prev_busy = 0;

  key_serial_loader #(.KEY_WIDTH(KW), .CHK_WIDTH(8), .FAIL_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready), .key_out(key_out), .key_valid(key_valid), .key_error(key_error),
    .busy(busy), .locked(locked), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xor_bytes(input logic [KW-1:0] k);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < KW / 8; i++) x ^= k[i*8 +: 8];
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a load either yields the key or a failure counted towards lockout.
  task automatic model_load(input logic [KW-1:0] k, input logic [7:0] c);
    if (mlock) return;
    if (c == xor_bytes(k)) exp_q.push_back({k, 1'b1, 1'b0, 3'(mfc), 1'b0});
    else begin
      mfc = (mfc < LIMIT) ? mfc + 1 : mfc;
      mlock = (mfc == LIMIT);
      exp_q.push_back({{KW{1'b0}}, 1'b0, 1'b1, 3'(mfc), mlock});
    end
  endtask

  task automatic send(input logic [KW+7:0] bits, input int n, input bit stall);
    for (int i = n - 1; i >= 0; i--) begin
      while (stall && $urandom_range(1, 0) == 1) begin
        in_valid = 1'b0;
        in_bit = 1'($urandom);
        tick();
      end
      in_valid = 1'b1;
      in_bit = bits[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    if (exp_q.size() != 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic load(input logic [KW-1:0] k, input logic [7:0] c, input bit stall);
    model_load(k, c);
    pulse_start();
    send({k, c}, KW + 8, stall);
    drain();
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    mfc = 0;
    mlock = 0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Monitor: a falling busy marks a resolved CHECK; key_out must read zero throughout a load.
  always @(negedge clk) begin
    if (!rst_n) prev_busy = 0;
    else begin
      if (busy) check("key_out_zero_while_busy", 64'(key_out), 64'd0);
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) check("unexpected_result", 64'd1, 64'd0);
        else check("result", 64'({key_out, key_valid, key_error, fail_count, locked}), 64'(exp_q.pop_front()));
      end
      prev_busy = busy;
    end
  end

  initial begin
    logic [KW-1:0] k;
    logic [7:0] c;
    #2;
    check("rst_key_out", 64'(key_out), 0);
    check("rst_flags", 64'({key_valid, key_error, busy, locked, in_ready}), 0);
    check("rst_fail_count", 64'(fail_count), 0);
    do_reset();

    // Good key, continuous stream, with exact latency.
    model_load(32'hA5C30F96, 8'hFF);
    pulse_start();
    send({32'hA5C30F96, 8'hFF}, KW + 8, 0);
    check("no_valid_before_check", 64'(key_valid), 0);
    tick();
    check("valid_at_41", 64'(key_valid), 1);
    check("good_key", 64'(key_out), 64'h0A5C30F96);
    drain();
    check("good_fail_count", 64'(fail_count), 0);

    // Bad checksum.
    load(32'hA5C30F96, 8'hFE, 0);
    check("bad_error", 64'({key_error, key_valid}), 64'b10);
    check("bad_fail_count", 64'(fail_count), 1);

    // Lockout.
    do_reset();
    repeat (3) load(32'hA5C30F96, 8'hFE, 0);
    check("locked", 64'(locked), 1);
    check("locked_in_ready", 64'(in_ready), 0);
    load(32'hA5C30F96, 8'hFF, 0);
    check("locked_key_out", 64'({key_out, key_valid}), 0);
    check("locked_still", 64'(locked), 1);
    do_reset();
    check("unlock_by_reset", 64'({locked, fail_count}), 0);

    // Abort after 12 bits, then a full good load.
    pulse_start();
    send({32'hDEADBEEF, 8'h00}, 12, 0);
    model_load(32'h12345678, 8'h08);
    pulse_start();
    send({32'h12345678, 8'h08}, KW + 8, 0);
    drain();
    check("abort_key", 64'(key_out), 64'h12345678);
    check("abort_fail_count", 64'(fail_count), 0);

    // Stalled stream.
    load(32'hA5C30F96, 8'hFF, 1);
    check("stall_key", 64'(key_out), 64'h0A5C30F96);

    // Randomized loads; relock is cleared by reset.
    for (int i = 0; i < 16; i++) begin
      k = $urandom;
      c = xor_bytes(k);
      if ($urandom_range(3, 0) == 0) c ^= 8'($urandom_range(255, 1));
      load(k, c, 1'($urandom));
      if (mlock) begin
        check("rand_locked", 64'(locked), 1);
        do_reset();
      end
    end

    // Reset mid-load clears outputs without a clock edge.
    pulse_start();
    send({32'hA5C30F96, 8'hFF}, 20, 0);
    rst_n = 1'b0;
    mfc = 0;
    mlock = 0;
    #1;
    check("midreset_key_out", 64'(key_out), 0);
    check("midreset_flags", 64'({key_valid, key_error, busy, locked, in_ready, fail_count}), 0);
    tick();
    rst_n = 1'b1;
    tick();
    load(32'h12345678, 8'h08, 0);
    check("after_reset_key", 64'(key_out), 64'h12345678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
